// File: rtl/hsv_core_pkg.sv
// Shared core types: instruction tokens, register masks and the in-flight controller state.
package hsv_core_pkg;

  localparam int TOKEN_W  = 3;
  localparam int NUM_REGS = 32;

  typedef logic [TOKEN_W-1:0]  insn_token;
  typedef logic [NUM_REGS-1:0] reg_mask;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } inflight_state_t;

  // x0 is hardwired zero, so it never takes part in hazard tracking.
  function automatic reg_mask strip_x0(input reg_mask m);
    return {m[NUM_REGS-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/hsv_core_inflight_ctrl_if.sv
// Issue/commit/flush bundle between the pipeline (master) and the in-flight controller (slave).
interface hsv_core_inflight_ctrl_if #(
  parameter int MAX_INFLIGHT = 4
) ();
  import hsv_core_pkg::*;

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic             issue_valid_i;
  logic             issue_ready_o;
  reg_mask          issue_rs_mask;
  reg_mask          issue_rd_mask;
  insn_token        issue_token_o;
  logic             commit_i;
  reg_mask          commit_mask;
  logic             flush_req;
  logic             flush_ack;
  logic [CNT_W-1:0] inflight_o;
  reg_mask          pending_o;

  modport master (
    output issue_valid_i, issue_rs_mask, issue_rd_mask, commit_i, commit_mask, flush_req,
    input  issue_ready_o, issue_token_o, flush_ack, inflight_o, pending_o
  );

  modport slave (
    input  issue_valid_i, issue_rs_mask, issue_rd_mask, commit_i, commit_mask, flush_req,
    output issue_ready_o, issue_token_o, flush_ack, inflight_o, pending_o
  );

endinterface

// File: rtl/hsv_core_inflight_scoreboard.sv
// Pending-destination scoreboard: per-register set/clear with set priority, plus a clear-all.
module hsv_core_inflight_scoreboard
  import hsv_core_pkg::*;
(
  input  logic    clk_core,
  input  logic    rst_core_n,
  input  reg_mask set_mask,
  input  reg_mask clr_mask,
  input  logic    clr_all,
  output reg_mask pending_mask
);

  reg_mask pending_reg;
  reg_mask pending_next;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      // A register retired and reissued in the same cycle must stay pending.
      assign pending_next[gi] = !clr_all &&
                                (set_mask[gi] || (pending_reg[gi] && !clr_mask[gi]));
    end
  endgenerate

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign pending_mask = pending_reg;

endmodule

// File: rtl/hsv_core_inflight_ctrl.sv
// In-flight instruction controller: issue gating on capacity and register hazards,
// token allocation, in-flight counting and flush handshake.
module hsv_core_inflight_ctrl #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                    clk_core,
  input  logic                    rst_core_n,
  hsv_core_inflight_ctrl_if.slave ctrl
);
  import hsv_core_pkg::*;

  localparam int               CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  inflight_state_t  state_reg;
  inflight_state_t  state_next;
  insn_token        token_reg;
  insn_token        token_next;
  logic [CNT_W-1:0] inflight_reg;
  logic [CNT_W-1:0] inflight_next;
  logic             flush_ack_reg;

  reg_mask pending;
  reg_mask set_mask;
  reg_mask clr_mask;
  logic    run_state;
  logic    hazard;
  logic    issue_ready;
  logic    fire;
  logic    commit_live;
  logic    commit_dec;
  logic    flush_clear;

  assign run_state   = (state_reg == RUN);
  assign hazard      = |strip_x0((ctrl.issue_rs_mask | ctrl.issue_rd_mask) & pending);
  // Reset gates ready combinationally so it is low for the whole reset window.
  assign issue_ready = rst_core_n && run_state && !ctrl.flush_req &&
                       (inflight_reg < MAX_CNT) && !hazard;
  assign fire        = ctrl.issue_valid_i && issue_ready;
  assign commit_live = ctrl.commit_i && run_state && !ctrl.flush_req;
  assign commit_dec  = commit_live && (inflight_reg != '0);
  assign flush_clear = run_state && ctrl.flush_req;

  assign set_mask = fire ? strip_x0(ctrl.issue_rd_mask) : '0;
  assign clr_mask = commit_live ? ctrl.commit_mask : '0;

  hsv_core_inflight_scoreboard u_scoreboard (
    .clk_core     (clk_core),
    .rst_core_n   (rst_core_n),
    .set_mask     (set_mask),
    .clr_mask     (clr_mask),
    .clr_all      (flush_clear),
    .pending_mask (pending)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (ctrl.flush_req)  state_next = FLUSH;
      FLUSH:   if (!ctrl.flush_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    token_next    = token_reg;
    inflight_next = inflight_reg;
    if (flush_clear) begin
      token_next    = '0;
      inflight_next = '0;
    end else begin
      if (fire) token_next = token_reg + insn_token'(1);
      case ({fire, commit_dec})
        2'b10:   inflight_next = inflight_reg + CNT_W'(1);
        2'b01:   inflight_next = inflight_reg - CNT_W'(1);
        default: inflight_next = inflight_reg;
      endcase
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_reg     <= RUN;
      token_reg     <= '0;
      inflight_reg  <= '0;
      flush_ack_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      token_reg     <= token_next;
      inflight_reg  <= inflight_next;
      flush_ack_reg <= ctrl.flush_req;
    end
  end

  assign ctrl.issue_ready_o = issue_ready;
  assign ctrl.issue_token_o = token_reg;
  assign ctrl.flush_ack     = flush_ack_reg;
  assign ctrl.inflight_o    = inflight_reg;
  assign ctrl.pending_o     = pending;

endmodule

// File: tb/tb_hsv_core_inflight_ctrl.sv
// Directed bench for hsv_core_inflight_ctrl; expected tokens are queued at drive time
// and compared when the controller accepts the instruction.
module tb_hsv_core_inflight_ctrl;
  import hsv_core_pkg::*;

  localparam int MAX_INFLIGHT = 4;

  logic clk_core   = 1'b0;
  logic rst_core_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int unsigned exp_tok_q[$];

  always #5 clk_core = ~clk_core;

  hsv_core_inflight_ctrl_if #(.MAX_INFLIGHT(MAX_INFLIGHT)) bus ();

  hsv_core_inflight_ctrl #(.MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .ctrl       (bus.slave)
  );

  task automatic check_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_cycle(input logic v, input reg_mask rs, input reg_mask rd,
                             input logic c, input reg_mask cm, input logic fl,
                             input logic chk_ready, input logic exp_ready, input string tag);
    @(negedge clk_core);
    bus.issue_valid_i = v;
    bus.issue_rs_mask = rs;
    bus.issue_rd_mask = rd;
    bus.commit_i      = c;
    bus.commit_mask   = cm;
    bus.flush_req     = fl;
    #1;
    if (chk_ready) check_result({tag, "_ready"}, 32'(bus.issue_ready_o), 32'(exp_ready));
    if (v && bus.issue_ready_o) begin
      check_result({tag, "_tok_q_size"}, 32'(exp_tok_q.size()), 32'd1);
      if (exp_tok_q.size() != 0)
        check_result({tag, "_token"}, 32'(bus.issue_token_o), exp_tok_q.pop_front());
    end
    $display("%0t %s v=%0b rdy=%0b tok=%0d c=%0b fl=%0b ack=%0b inflight=%0d pending=%08h",
             $time, tag, v, bus.issue_ready_o, bus.issue_token_o, c, fl, bus.flush_ack,
             bus.inflight_o, bus.pending_o);
  endtask

  task automatic send(input reg_mask rs, input reg_mask rd, input logic c, input reg_mask cm,
                      input logic fl, input logic exp_ready, input int unsigned exp_tok,
                      input string tag);
    if (exp_ready) exp_tok_q.push_back(exp_tok);
    drive_cycle(1'b1, rs, rd, c, cm, fl, 1'b1, exp_ready, tag);
  endtask

  task automatic idle(input logic c, input reg_mask cm, input logic fl, input string tag);
    drive_cycle(1'b0, '0, '0, c, cm, fl, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Valid held high in reset: ready must still be low.
    bus.issue_valid_i = 1'b1;
    bus.issue_rs_mask = '0;
    bus.issue_rd_mask = '0;
    bus.commit_i      = 1'b0;
    bus.commit_mask   = '0;
    bus.flush_req     = 1'b0;
    #2;
    check_result("rst_ready",    32'(bus.issue_ready_o), 32'd0);
    check_result("rst_token",    32'(bus.issue_token_o), 32'd0);
    check_result("rst_inflight", 32'(bus.inflight_o),    32'd0);
    check_result("rst_pending",  bus.pending_o,          32'd0);
    check_result("rst_ack",      32'(bus.flush_ack),     32'd0);
    bus.issue_valid_i = 1'b0;
    repeat (2) @(negedge clk_core);
    rst_core_n = 1'b1;

    // Fill to capacity with rd x1..x4.
    for (int i = 0; i < 4; i++)
      send('0, reg_mask'(1) << (i + 1), 1'b0, '0, 1'b0, 1'b1, i, "t1_fill");
    send('0, reg_mask'(1) << 6, 1'b0, '0, 1'b0, 1'b0, 0, "t1_full");
    check_result("t1_inflight", 32'(bus.inflight_o),    32'd4);
    check_result("t1_pending",  bus.pending_o,          32'h0000_001E);
    check_result("t1_token",    32'(bus.issue_token_o), 32'd4);

    // Source hazard on x5 released by a commit: blocked this cycle, issuable the next.
    idle(1'b1, reg_mask'(1) << 1, 1'b0, "t2_commit_x1");
    send('0, reg_mask'(1) << 5, 1'b0, '0, 1'b0, 1'b1, 4, "t2_issue_x5");
    idle(1'b1, reg_mask'(1) << 2, 1'b0, "t2_commit_x2");
    send(reg_mask'(1) << 5, '0, 1'b1, reg_mask'(1) << 5, 1'b0, 1'b0, 0, "t2_hazard");
    send(reg_mask'(1) << 5, '0, 1'b0, '0, 1'b0, 1'b1, 5, "t2_release");

    // Fire and commit together at inflight 2.
    idle(1'b1, reg_mask'(1) << 3, 1'b0, "t3_commit_x3");
    send('0, reg_mask'(1) << 7, 1'b1, reg_mask'(1) << 4, 1'b0, 1'b1, 6, "t3_both");
    check_result("t3_inflight_before", 32'(bus.inflight_o), 32'd2);
    idle(1'b0, '0, 1'b0, "t3_idle");
    check_result("t3_inflight_after", 32'(bus.inflight_o),    32'd2);
    check_result("t3_pending",        bus.pending_o,          32'h0000_0080);
    check_result("t3_token",          32'(bus.issue_token_o), 32'd7);

    // Nine issues with a commit after each: token sequence 7,0,1,...,7.
    for (int i = 0; i < 9; i++) begin
      send('0, reg_mask'(1) << (8 + i), 1'b0, '0, 1'b0, 1'b1, (7 + i) % 8, "t4_wrap");
      idle(1'b1, reg_mask'(1) << (8 + i), 1'b0, "t4_commit");
    end
    // rd = x0 is never recorded as pending.
    send('0, reg_mask'(1), 1'b0, '0, 1'b0, 1'b1, 0, "t4_rd_x0");
    idle(1'b1, '0, 1'b0, "t4_commit_x0");
    check_result("t4_pending",  bus.pending_o,       32'h0000_0080);
    check_result("t4_inflight", 32'(bus.inflight_o), 32'd3);

    // Reach inflight 3 / next-token 5, then flush with a competing fire and commit.
    for (int i = 1; i < 4; i++)
      send('0, '0, 1'b1, '0, 1'b0, 1'b1, i, "t5_prep");
    send('0, reg_mask'(1) << 9, 1'b0, '0, 1'b0, 1'b1, 4, "t5_prep_x9");
    send('0, reg_mask'(1) << 10, 1'b1, reg_mask'(1) << 7, 1'b1, 1'b0, 0, "t5_flush_block");
    check_result("t5_pre_inflight", 32'(bus.inflight_o),    32'd3);
    check_result("t5_pre_token",    32'(bus.issue_token_o), 32'd5);
    send('0, '0, 1'b1, reg_mask'(1) << 9, 1'b1, 1'b0, 0, "t5_in_flush");
    check_result("t5_ack",      32'(bus.flush_ack),     32'd1);
    check_result("t5_inflight", 32'(bus.inflight_o),    32'd0);
    check_result("t5_pending",  bus.pending_o,          32'd0);
    check_result("t5_token",    32'(bus.issue_token_o), 32'd0);
    send('0, '0, 1'b1, '0, 1'b0, 1'b0, 0, "t5_drop");
    check_result("t5_ack_hold", 32'(bus.flush_ack), 32'd1);
    send('0, reg_mask'(1) << 3, 1'b0, '0, 1'b0, 1'b1, 0, "t5_resume");
    check_result("t5_ack_low", 32'(bus.flush_ack), 32'd0);

    // Asynchronous reset in the middle of a flush.
    idle(1'b0, '0, 1'b1, "t6_flush");
    @(posedge clk_core);
    #2;
    check_result("t6_ack_in_flush", 32'(bus.flush_ack), 32'd1);
    bus.issue_valid_i = 1'b1;
    rst_core_n = 1'b0;
    #1;
    check_result("t6_rst_ack",      32'(bus.flush_ack),     32'd0);
    check_result("t6_rst_ready",    32'(bus.issue_ready_o), 32'd0);
    check_result("t6_rst_inflight", 32'(bus.inflight_o),    32'd0);
    check_result("t6_rst_pending",  bus.pending_o,          32'd0);
    check_result("t6_rst_token",    32'(bus.issue_token_o), 32'd0);
    @(negedge clk_core);
    bus.issue_valid_i = 1'b0;
    bus.flush_req     = 1'b0;
    rst_core_n        = 1'b1;

    // A commit at inflight 0 must not underflow.
    idle(1'b1, '0, 1'b0, "t6_commit_at_zero");
    idle(1'b0, '0, 1'b0, "t6_idle");
    check_result("t6_inflight_zero", 32'(bus.inflight_o), 32'd0);
    send(reg_mask'(1) << 3, reg_mask'(1) << 3, 1'b0, '0, 1'b0, 1'b1, 0, "t6_after_rst");
    idle(1'b0, '0, 1'b0, "t6_idle2");
    check_result("t6_inflight_one", 32'(bus.inflight_o), 32'd1);
    check_result("t6_pending_x3",   bus.pending_o,       32'h0000_0008);

    check_result("tok_q_drained", 32'(exp_tok_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsv_core_inflight_ctrl.md
HSV_CORE_INFLIGHT_CTRL -- requirements
Module: hsv_core_inflight_ctrl

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, giving the maximum number of issued but not yet committed instructions; legal range 1..2**$bits(insn_token).
REQ-002 clk_core  in  1  core clock; all state SHALL update on its rising edge.
REQ-003 rst_core_n  in  1  reset, asynchronous, active-low.
REQ-004 issue_valid_i  in  1  issue stage presents an instruction.
REQ-005 issue_ready_o  out  1  controller accepts it; fire = issue_valid_i & issue_ready_o.
REQ-006 issue_rs_mask  in  reg_mask  source registers read by the instruction.
REQ-007 issue_rd_mask  in  reg_mask  destination register (one-hot or zero).
REQ-008 issue_token_o  out  insn_token  token assigned to the presented instruction.
REQ-009 commit_i  in  1  one instruction committed this cycle (commit-stage ctrl_commit).
REQ-010 commit_mask  in  reg_mask  rd mask released by that commit.
REQ-011 flush_req  in  1  pipeline flush request, level.
REQ-012 flush_ack  out  1  flush completed; bookkeeping is cleared.
REQ-013 inflight_o  out  $clog2(MAX_INFLIGHT+1)  current in-flight count.
REQ-014 pending_o  out  reg_mask  current scoreboard.

Function
REQ-015 States SHALL be RUN and FLUSH only.
- RUN->FLUSH when flush_req=1.
- FLUSH->RUN when flush_req=0.
REQ-016 issue_ready_o SHALL be 1 only when all of the following hold:
- state is RUN and flush_req=0.
- inflight_o < MAX_INFLIGHT.
- (issue_rs_mask | issue_rd_mask) & pending_o, bit 0 excluded, is zero.
REQ-017 issue_ready_o SHALL have no combinational bypass from commit_i or commit_mask; a register released this cycle is issuable the next cycle.
REQ-018 issue_token_o SHALL equal the next-token register. The register SHALL increment by 1 on each fire and wrap modulo 2**$bits(insn_token).
REQ-019 On fire, pending_o SHALL OR in issue_rd_mask with bit 0 forced 0, visible the next cycle.
REQ-020 On commit_i=1, pending_o SHALL clear the commit_mask bits, visible the next cycle.
REQ-021 On a simultaneous set and clear of the same bit, set SHALL win.
REQ-022 inflight_o SHALL update as follows:
- +1 on fire alone.
- -1 on commit_i alone.
- unchanged when both occur in the same cycle.
- saturate at 0; commit_i at 0 is ignored.
REQ-023 Next cycle after flush_req is sampled high in RUN, the block SHALL do all of the following:
- next-token = 0.
- pending_o = 0.
- inflight_o = 0.
- state = FLUSH.
- flush_ack = 1.
REQ-024 flush_ack SHALL follow flush_req with exactly one cycle of latency (registered). It therefore drops one cycle after flush_req drops.
REQ-025 While in FLUSH, commit_i and commit_mask SHALL be ignored, and no fire SHALL occur.
REQ-026 A flush_req arriving in the same cycle as a fire candidate SHALL block the fire.

Reset
REQ-027 While rst_core_n=0, the block SHALL hold the following values:
- state = RUN.
- next-token = 0.
- pending_o = 0.
- inflight_o = 0.
- flush_ack = 0.
- issue_ready_o low until rst_core_n=1.
REQ-028 Reset mid-flush SHALL return the block to RUN with flush_ack=0 immediately (asynchronous).

Structure
REQ-029 insn_token, reg_mask and the state enum inflight_state_t SHALL come from hsv_core_pkg. MAX_INFLIGHT stays a module parameter.
REQ-030 The scoreboard SHALL be the sub-module hsv_core_inflight_scoreboard, with inputs set mask, clear mask and clear-all, and output pending mask.

Verification
REQ-031 Reset, then 4 fires with rd x1..x4 and no commits:
- tokens 0,1,2,3 are issued.
- inflight_o=4.
- issue_ready_o=0 on the 5th instruction.
REQ-032 Instruction with rs x5 while x5 is pending; commit_i=1 with commit_mask bit5:
- issue_ready_o=0 in the commit cycle.
- issue_ready_o=1 in the next cycle.
REQ-033 Fire and commit in the same cycle at inflight_o=2:
- inflight_o stays 2.
- token increments.
REQ-034 Issue 9 instructions with MAX_INFLIGHT=4 and a commit after each:
- token wraps 7->0 for an 8-token width.
REQ-035 Raise flush_req with inflight_o=3 and next-token=5:
- next cycle: flush_ack=1, inflight_o=0, pending_o=0, issue_token_o=0.
- then drop flush_req: flush_ack=0 one cycle later, and issue resumes at token 0.
REQ-036 Assert rst_core_n=0 during FLUSH:
- all outputs are at their reset values without waiting for a clock edge.
